// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the hazard/execute logic (master) and the PC generator (slave).
interface pc_gen_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH   = 32
);
  logic                     stall;
  logic                     redirect_valid;
  logic [ADDRESS_WIDTH-1:0] redirect_target;
  logic                     trap_valid;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic                     pc_valid;
  logic                     pc_redirected;
  logic [COUNT_WIDTH-1:0]   fetch_count;
  logic                     misaligned;

  modport master (
    output stall, redirect_valid, redirect_target, trap_valid,
    input  pc, pc_valid, pc_redirected, fetch_count, misaligned
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap_valid,
    output pc, pc_valid, pc_redirected, fetch_count, misaligned
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter with stall, prioritised trap/redirect, stalled-redirect buffer
// and fetch counter. Define PC_GEN_MISALIGN_TRAP_EN to turn misaligned redirect targets into traps.
module pc_gen #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter logic [31:0]              TRAP_VECTOR   = 32'h0000_0100,
  parameter int unsigned              INSTR_BYTES   = 4,
  parameter int unsigned              COUNT_WIDTH   = 32
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

`ifdef PC_GEN_MISALIGN_TRAP_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  localparam logic [ADDRESS_WIDTH-1:0] TRAP_PC   = ADDRESS_WIDTH'(TRAP_VECTOR);
  localparam logic [ADDRESS_WIDTH-1:0] STEP      = ADDRESS_WIDTH'(INSTR_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MSK = ADDRESS_WIDTH'(INSTR_BYTES - 1);

  typedef enum logic [1:0] {BOOT, RUN, PENDING} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     redir_q, redir_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     mis_q, mis_d;
  logic [ADDRESS_WIDTH-1:0] pend_target_q, pend_target_d;
  logic                     pend_is_trap_q, pend_is_trap_d;

  function automatic logic bad_align(input logic [ADDRESS_WIDTH-1:0] t);
    return MISALIGN_EN && ((t & ALIGN_MSK) != '0);
  endfunction

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    redir_d        = 1'b0;
    count_d        = count_q;
    mis_d          = mis_q;
    pend_target_d  = pend_target_q;
    pend_is_trap_d = pend_is_trap_q;

    unique case (state_q)
      BOOT: state_d = RUN;

      RUN: begin
        if (bus.stall) begin
          if (bus.trap_valid) begin
            pend_target_d  = TRAP_PC;
            pend_is_trap_d = 1'b1;
            state_d        = PENDING;
          end else if (bus.redirect_valid) begin
            pend_target_d  = bus.redirect_target;
            pend_is_trap_d = 1'b0;
            state_d        = PENDING;
          end
        end else begin
          count_d = count_q + COUNT_WIDTH'(1);
          if (bus.trap_valid) begin
            pc_d    = TRAP_PC;
            redir_d = 1'b1;
          end else if (bus.redirect_valid) begin
            redir_d = 1'b1;
            if (bad_align(bus.redirect_target)) begin
              pc_d  = TRAP_PC;
              mis_d = 1'b1;
            end else begin
              pc_d  = bus.redirect_target;
            end
          end else begin
            pc_d = pc_q + STEP;
          end
        end
      end

      PENDING: begin
        if (bus.stall) begin
          if (bus.trap_valid) begin
            pend_target_d  = TRAP_PC;
            pend_is_trap_d = 1'b1;
          end else if (bus.redirect_valid && !pend_is_trap_q) begin
            pend_target_d  = bus.redirect_target;
          end
        end else begin
          // The buffered target is older than any redirect arriving now, so the new one is dropped.
          count_d = count_q + COUNT_WIDTH'(1);
          redir_d = 1'b1;
          state_d = RUN;
          if (bus.trap_valid) begin
            pc_d = TRAP_PC;
          end else if (!pend_is_trap_q && bad_align(pend_target_q)) begin
            pc_d  = TRAP_PC;
            mis_d = 1'b1;
          end else begin
            pc_d = pend_target_q;
          end
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the pending buffer is reset too, so a stale target can never leak out after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= BOOT;
      pc_q           <= RESET_VECTOR;
      redir_q        <= 1'b0;
      count_q        <= '0;
      mis_q          <= 1'b0;
      pend_target_q  <= '0;
      pend_is_trap_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      redir_q        <= redir_d;
      count_q        <= count_d;
      mis_q          <= mis_d;
      pend_target_q  <= pend_target_d;
      pend_is_trap_q <= pend_is_trap_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_valid      = (state_q != BOOT);
  assign bus.pc_redirected = redir_q;
  assign bus.fetch_count   = count_q;
  assign bus.misaligned    = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a transaction-level model is compared every cycle, plus literal pins.
module tb_pc_gen;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 32;
  localparam logic [31:0] RV = 32'h0000_1000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int unsigned IB = 4;
`ifdef PC_GEN_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  pc_gen_if #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

  pc_gen #(
    .ADDRESS_WIDTH(AW), .RESET_VECTOR(RV), .TRAP_VECTOR(TV),
    .INSTR_BYTES(IB), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: "booting" flag, a one-deep mailbox of deferred control transfers, and the counters.
  bit          m_init = 1'b0;
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_redir;
  logic [31:0] m_count;
  bit          m_mis;
  bit          m_has_pend;
  logic [31:0] m_pend_tgt;
  bit          m_pend_trap;

  function automatic logic [31:0] resolve(input logic [31:0] tgt, input bit is_trap, inout bit mis);
    if (!is_trap && MIS_EN && (tgt % IB) != 0) begin
      mis = 1'b1;
      return TV;
    end
    return tgt;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1; m_boot = 1'b1; m_pc = RV; m_redir = 1'b0;
      m_count = '0; m_mis = 1'b0; m_has_pend = 1'b0; m_pend_tgt = '0; m_pend_trap = 1'b0;
    end else if (m_init) begin
      if (m_boot) begin
        m_boot  = 1'b0;
        m_redir = 1'b0;
      end else if (bus.stall) begin
        m_redir = 1'b0;
        if (bus.trap_valid) begin
          m_has_pend = 1'b1; m_pend_tgt = TV; m_pend_trap = 1'b1;
        end else if (bus.redirect_valid && !(m_has_pend && m_pend_trap)) begin
          m_has_pend = 1'b1; m_pend_tgt = bus.redirect_target; m_pend_trap = 1'b0;
        end
      end else begin
        m_count++;
        m_redir = 1'b1;
        if (bus.trap_valid)          m_pc = TV;
        else if (m_has_pend)         m_pc = resolve(m_pend_tgt, m_pend_trap, m_mis);
        else if (bus.redirect_valid) m_pc = resolve(bus.redirect_target, 1'b0, m_mis);
        else begin
          m_pc    = m_pc + IB;
          m_redir = 1'b0;
        end
        m_has_pend = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("model_pc",       64'(bus.pc),            64'(m_pc));
      check("model_pc_valid", 64'(bus.pc_valid),      64'(!m_boot));
      check("model_redir",    64'(bus.pc_redirected), 64'(m_redir));
      check("model_count",    64'(bus.fetch_count),   64'(m_count));
      check("model_mis",      64'(bus.misaligned),    64'(m_mis));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit s, input bit r, input logic [31:0] t, input bit tr);
    bus.stall = s; bus.redirect_valid = r; bus.redirect_target = t; bus.trap_valid = tr;
  endtask

  logic [31:0] held_cnt;

  initial begin
    rst = 1'b1;
    drive(0, 0, 32'h0, 0);
    step(2);
    check("rst_pc",    64'(bus.pc), 64'h1000);
    check("rst_valid", 64'(bus.pc_valid), 64'h0);
    check("rst_count", 64'(bus.fetch_count), 64'h0);
    check("rst_redir", 64'(bus.pc_redirected), 64'h0);
    check("rst_mis",   64'(bus.misaligned), 64'h0);
    rst = 1'b0;
    step();
    check("boot_valid", 64'(bus.pc_valid), 64'h1);
    check("boot_pc",    64'(bus.pc), 64'h1000);
    step();
    check("seq1_pc",    64'(bus.pc), 64'h1004);
    check("seq1_count", 64'(bus.fetch_count), 64'h1);
    step();
    check("seq2_pc",    64'(bus.pc), 64'h1008);
    check("seq2_count", 64'(bus.fetch_count), 64'h2);

    drive(0, 1, 32'h2000, 0); step();
    check("redir_pc",   64'(bus.pc), 64'h2000);
    check("redir_flag", 64'(bus.pc_redirected), 64'h1);
    drive(0, 0, 32'h0, 0); step();
    check("redir_next", 64'(bus.pc), 64'h2004);
    check("redir_pulse_end", 64'(bus.pc_redirected), 64'h0);

    drive(0, 1, 32'h3000, 1); step();
    check("trap_wins", 64'(bus.pc), 64'h100);
    drive(0, 0, 32'h0, 0); step();
    check("trap_next", 64'(bus.pc), 64'h104);

    held_cnt = bus.fetch_count;
    drive(1, 1, 32'h4000, 0); step();
    drive(1, 1, 32'h5000, 0); step();
    drive(1, 0, 32'h0, 0);    step();
    check("stall_pc",    64'(bus.pc), 64'h104);
    check("stall_count", 64'(bus.fetch_count), 64'(held_cnt));
    drive(0, 0, 32'h0, 0); step();
    check("pend_drain", 64'(bus.pc), 64'h5000);
    check("pend_redir", 64'(bus.pc_redirected), 64'h1);

    drive(1, 0, 32'h0, 1);    step();
    drive(1, 1, 32'h5000, 0); step();
    drive(1, 0, 32'h0, 0);    step();
    drive(0, 0, 32'h0, 0);    step();
    check("pend_trap_kept", 64'(bus.pc), 64'h100);

    drive(1, 1, 32'h7100, 0); step();
    drive(0, 1, 32'h7200, 0); step();
    check("pend_older_wins", 64'(bus.pc), 64'h7100);
    drive(1, 1, 32'h7000, 0); step();
    drive(0, 0, 32'h0, 1);    step();
    check("pend_trap_override", 64'(bus.pc), 64'h100);

    drive(0, 1, 32'hFFFF_FFFC, 0); step();
    drive(0, 0, 32'h0, 0); step();
    check("wrap_pc", 64'(bus.pc), 64'h0);

    drive(1, 1, 32'h6000, 0); step();
    rst = 1'b1; step();
    rst = 1'b0; drive(0, 0, 32'h0, 0);
    check("midpend_rst_pc",    64'(bus.pc), 64'h1000);
    check("midpend_rst_count", 64'(bus.fetch_count), 64'h0);
    step(2);
    check("midpend_discard", 64'(bus.pc), 64'h1004);

    drive(0, 1, 32'h2002, 0); step();
    check("mis_pc",   64'(bus.pc), MIS_EN ? 64'h100 : 64'h2002);
    check("mis_flag", 64'(bus.misaligned), 64'(MIS_EN));
    drive(0, 0, 32'h0, 0); step(3);
    check("mis_sticky", 64'(bus.misaligned), 64'(MIS_EN));
    drive(1, 1, 32'h3006, 0); step();
    drive(0, 0, 32'h0, 0);    step();
    check("mis_pend_pc", 64'(bus.pc), MIS_EN ? 64'h100 : 64'h3006);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
